// File: rtl/lbp_code_builder.sv
// Builds an 8-bit circular LBP code from eight neighbour samples aligned to a
// fixed-latency interpolator, with popcount and uniform-pattern flag.
module lbp_code_builder #(
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_first,
  input  logic [7:0] center,
  input  logic [7:0] I,
  output logic       out_valid,
  output logic [7:0] lbp_code,
  output logic [3:0] ones,
  output logic       uniform,
  output logic       err
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  logic [LATENCY-1:0] r_dly_valid;
  logic [LATENCY-1:0] r_dly_first;
  logic [7:0]         r_dly_center [LATENCY];

  state_t     r_state;
  logic [2:0] r_idx;
  logic [7:0] r_code;
  logic [7:0] r_c;

  logic       w_d_valid;
  logic       w_d_first;
  logic [7:0] w_d_center;
  logic       w_bit_first;
  logic       w_bit_acc;
  logic [7:0] w_final_code;
  logic [3:0] w_ones;
  logic       w_uniform;

  // NOTE: the sideband delay line is a small register array, not a RAM, so it
  // is cleared on reset; a stale valid would otherwise fire after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_valid <= '0;
      r_dly_first <= '0;
      for (int k = 0; k < LATENCY; k++) r_dly_center[k] <= '0;
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        r_dly_valid[k]  <= r_dly_valid[k-1];
        r_dly_first[k]  <= r_dly_first[k-1];
        r_dly_center[k] <= r_dly_center[k-1];
      end
      r_dly_valid[0]  <= in_valid;
      r_dly_first[0]  <= in_first & in_valid;
      r_dly_center[0] <= center;
    end
  end

  assign w_d_valid  = r_dly_valid[LATENCY-1];
  assign w_d_first  = r_dly_first[LATENCY-1];
  assign w_d_center = r_dly_center[LATENCY-1];

  // Ties count as 1; bit 7 of the partial code is always still clear here.
  assign w_bit_first  = (I >= w_d_center);
  assign w_bit_acc    = (I >= r_c);
  assign w_final_code = {w_bit_acc, r_code[6:0]};
  assign w_ones       = 4'($countones(w_final_code));
  assign w_uniform    = ($countones(w_final_code ^ {w_final_code[0], w_final_code[7:1]}) <= 2);

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_code    <= '0;
      r_c       <= '0;
      out_valid <= 1'b0;
      lbp_code  <= '0;
      ones      <= '0;
      uniform   <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (w_d_valid) begin
        if (w_d_first) begin
          // A first sample always opens a pixel; inside ACCUM it aborts the old one.
          err     <= (r_state == S_ACCUM);
          r_c     <= w_d_center;
          r_code  <= {7'd0, w_bit_first};
          r_idx   <= 3'd1;
          r_state <= S_ACCUM;
        end else if (r_state == S_IDLE) begin
          err <= 1'b1;
        end else if (r_idx == 3'd7) begin
          lbp_code  <= w_final_code;
          ones      <= w_ones;
          uniform   <= w_uniform;
          out_valid <= 1'b1;
          r_code    <= '0;
          r_idx     <= '0;
          r_state   <= S_IDLE;
        end else begin
          r_code[r_idx] <= w_bit_acc;
          r_idx         <= r_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbp_code_builder.sv
// Self-checking bench: directed scenarios plus random request streams, compared
// every cycle against a queue-based pixel assembly model.
module tb_lbp_code_builder;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_first;
  logic [7:0] center;
  logic [7:0] I;
  logic       out_valid;
  logic [7:0] lbp_code;
  logic [3:0] ones;
  logic       uniform;
  logic       err;

  always #5 clk = ~clk;

  lbp_code_builder #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .center   (center),
    .I        (I),
    .out_valid(out_valid),
    .lbp_code (lbp_code),
    .ones     (ones),
    .uniform  (uniform),
    .err      (err)
  );

  typedef struct {
    bit          v;
    bit          f;
    logic [7:0]  c;
  } req_t;

  int n_checks = 0;
  int n_pass   = 0;

  req_t       side_q[$];
  logic [7:0] i_q[$];
  logic [7:0] pix[$];
  logic [7:0] pix_c;
  bit         e_valid, e_err, e_uni;
  logic [7:0] e_code;
  int         e_ones;
  int         n_valid_seen;
  int         n_err_seen;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Score the completed pixel from its eight stored samples.
  task automatic score_pixel();
    int trans;
    e_code = '0;
    for (int k = 0; k < 8; k++) if (pix[k] >= pix_c) e_code[k] = 1'b1;
    e_ones = 0;
    trans  = 0;
    for (int k = 0; k < 8; k++) begin
      e_ones += int'(e_code[k]);
      if (e_code[k] != e_code[(k + 1) % 8]) trans++;
    end
    e_uni = (trans <= 2);
  endtask

  // One clock: drive a request (ival is the I value that request will produce
  // LAT cycles later), update the model at the edge, compare on the falling edge.
  task automatic step(input bit r, input bit v, input bit f, input logic [7:0] c,
                      input logic [7:0] ival);
    req_t       a;
    logic [7:0] cur_i;
    rst      = r;
    in_valid = v;
    in_first = f;
    center   = c;
    i_q.push_back(ival);
    cur_i = i_q.pop_front();
    I     = cur_i;
    @(posedge clk);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      side_q.delete();
      repeat (LAT) side_q.push_back('{v: 1'b0, f: 1'b0, c: 8'd0});
      pix.delete();
      e_code = '0;
      e_ones = 0;
      e_uni  = 1'b0;
    end else begin
      side_q.push_back('{v: v, f: f & v, c: c});
      a = side_q.pop_front();
      if (a.v) begin
        if (a.f) begin
          if (pix.size() != 0) e_err = 1'b1;
          pix.delete();
          pix.push_back(cur_i);
          pix_c = a.c;
        end else if (pix.size() == 0) begin
          e_err = 1'b1;
        end else begin
          pix.push_back(cur_i);
          if (pix.size() == 8) begin
            score_pixel();
            e_valid = 1'b1;
            pix.delete();
          end
        end
      end
    end
    @(negedge clk);
    check("out_valid", int'(out_valid), int'(e_valid));
    check("err",       int'(err),       int'(e_err));
    check("lbp_code",  int'(lbp_code),  int'(e_code));
    check("ones",      int'(ones),      e_ones);
    check("uniform",   int'(uniform),   int'(e_uni));
    if (out_valid) n_valid_seen++;
    if (err) n_err_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'(($urandom)), 8'($urandom), 8'($urandom));
  endtask

  // Eight requests for one pixel; two bubble cycles follow sample k when gaps[k] is set.
  task automatic send_pixel(input logic [7:0] c, input logic [7:0] vals [8],
                            input logic [7:0] gaps);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, (k == 0), c, vals[k]);
      if (gaps[k]) idle(2);
    end
  endtask

  initial begin
    logic [7:0] gen_c;
    int         gen_n;
    bit         f;
    logic [7:0] ival;
    int         cyc0;

    n_valid_seen = 0;
    n_err_seen   = 0;
    repeat (LAT) i_q.push_back(8'd0);
    repeat (LAT) side_q.push_back('{v: 1'b0, f: 1'b0, c: 8'd0});
    pix_c = '0;

    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd9, 8'd9);
    idle(2);

    // Scenario 1: mixed above/below/tie samples, also checks out_valid timing.
    n_valid_seen = 0;
    send_pixel(8'd100, '{8'd120, 8'd90, 8'd100, 8'd50, 8'd200, 8'd99, 8'd101, 8'd0}, 8'h00);
    idle(LAT - 1);
    check("s1_no_early_valid", n_valid_seen, 0);
    idle(1);
    check("s1_valid_pulse", int'(out_valid), 1);
    check("s1_code", int'(lbp_code), 8'h55);
    check("s1_ones", int'(ones), 4);
    check("s1_uniform", int'(uniform), 0);
    idle(2);

    // Scenario 2: all ties, then only the last neighbour reaches the centre.
    send_pixel(8'd10, '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'h00);
    idle(LAT + 1);
    check("s2a_code", int'(lbp_code), 8'hFF);
    check("s2a_uniform", int'(uniform), 1);
    send_pixel(8'd255, '{8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd255}, 8'h00);
    idle(LAT + 1);
    check("s2b_code", int'(lbp_code), 8'h80);
    check("s2b_ones", int'(ones), 1);

    // Scenario 3: bubbles after samples 2 and 5.
    send_pixel(8'd100, '{8'd120, 8'd90, 8'd100, 8'd50, 8'd200, 8'd99, 8'd101, 8'd0}, 8'h24);
    idle(LAT + 1);
    check("s3_code", int'(lbp_code), 8'h55);

    // Scenario 4: early restart after five samples.
    n_err_seen   = 0;
    n_valid_seen = 0;
    step(1'b0, 1'b1, 1'b1, 8'd200, 8'd1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd255);
    send_pixel(8'd0, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'h00);
    idle(LAT + 1);
    check("s4_err_count", n_err_seen, 1);
    check("s4_valid_count", n_valid_seen, 1);
    check("s4_code", int'(lbp_code), 8'hFF);

    // Scenario 5: orphan sample while idle, then a good pixel.
    n_err_seen   = 0;
    n_valid_seen = 0;
    step(1'b0, 1'b1, 1'b0, 8'd77, 8'd5);
    idle(LAT);
    check("s5_err_count", n_err_seen, 1);
    send_pixel(8'd50, '{8'd0, 8'd60, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'h00);
    idle(LAT + 1);
    check("s5_valid_count", n_valid_seen, 1);
    check("s5_code", int'(lbp_code), 8'h06);

    // Scenario 6: reset mid-pixel, then a clean pixel with code 0x0F.
    step(1'b0, 1'b1, 1'b1, 8'd10, 8'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    check("s6_rst_code", int'(lbp_code), 0);
    check("s6_rst_ones", int'(ones), 0);
    n_valid_seen = 0;
    idle(LAT + 2);
    check("s6_no_stale", n_valid_seen, 0);
    send_pixel(8'h80, '{8'd200, 8'd128, 8'd255, 8'd130, 8'd0, 8'd1, 8'd127, 8'd50}, 8'h00);
    idle(LAT + 1);
    check("s6_valid_count", n_valid_seen, 1);
    check("s6_code", int'(lbp_code), 8'h0F);
    check("s6_uniform", int'(uniform), 1);

    // Random stream: bubbles, ties, early restarts, orphans, rare resets.
    gen_n = 0;
    gen_c = '0;
    cyc0  = n_checks;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom % 500 == 0) begin
        step(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
        gen_n = 0;
      end else if ($urandom % 6 == 0) begin
        idle(1);
      end else begin
        f = (gen_n == 0);
        if ($urandom % 40 == 0) f = !f;
        if (f) begin
          gen_c = 8'($urandom);
          gen_n = 1;
        end else if (gen_n != 0) begin
          gen_n = (gen_n == 7) ? 0 : gen_n + 1;
        end
        case ($urandom % 4)
          0:       ival = gen_c;
          1:       ival = gen_c + 8'd1;
          2:       ival = gen_c - 8'd1;
          default: ival = 8'($urandom);
        endcase
        step(1'b0, 1'b1, f, f ? gen_c : 8'($urandom), ival);
      end
    end
    idle(LAT + 2);
    check("random_ran", int'(n_checks > cyc0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lbp_code_builder.md
Name: lbp_code_builder

Overview:
- Downstream consumer of the bilinear interpolation stage in the circular-LBP path.
- Collects the 8 neighbour samples of one pixel, in order f c b a d g h i, then thresholds each sample against the pixel's centre value.
- Emits a registered 8-bit LBP code plus a ones count and a uniform-pattern flag.
- The interpolator has a fixed latency and no valid signal, so this block delays its own valid/first/centre sideband by LATENCY to align it with the interpolator's I output.

Parameters:
- LATENCY, 3: cycles from interpolator input (in_valid asserted) to matching I at this block's input; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a sample request entered the interpolator this cycle.
- in_first  input  1  with in_valid: this request is neighbour 0 (f) of a new pixel.
- center  input  8  centre pixel value; sampled only when in_valid & in_first.
- I  input  8  interpolated or direct neighbour value; valid LATENCY cycles after its in_valid.
- out_valid  output  1  one-cycle pulse: lbp_code, ones and uniform are valid.
- lbp_code  output  8  bit k = (neighbour k >= centre), k = 0..7 in f c b a d g h i order.
- ones  output  4  popcount of lbp_code, 0..8.
- uniform  output  1  circular 0/1 transition count of lbp_code <= 2.
- err  output  1  one-cycle pulse on a sequence error.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, lbp_code=0, ones=0, uniform=0, err=0; delay line cleared; state=IDLE, idx=0, partial code=0, latched centre=0. Reset always wins and aborts any partial pixel.
- Delay line:
  - LATENCY-deep shift register carries {in_valid, in_first & in_valid, center}; its output is d_valid, d_first, d_center.
  - It shifts every cycle, so bubbles (in_valid=0) propagate.
- FSM, states IDLE and ACCUM:
  - IDLE, d_valid & d_first: latch c=d_center; bit0=(I>=d_center); idx<=1; go to ACCUM.
  - IDLE, d_valid & !d_first: sample dropped; err pulses next cycle; stay in IDLE.
  - ACCUM, d_valid & !d_first: bit[idx]=(I>=c); idx++. If idx was 7: register outputs, pulse out_valid next cycle, clear partial code, go to IDLE.
  - ACCUM, d_valid & d_first (early restart): err pulses; partial pixel discarded; the sample is treated as neighbour 0 of a new pixel (c re-latched, idx<=1), stay in ACCUM.
  - Any state, d_valid=0: hold everything.
- Timing:
  - Comparison is unsigned 8-bit; a tie (I == c) gives 1.
  - Output latency: out_valid is asserted exactly 1 cycle after the cycle the 8th aligned sample is consumed.
  - Back-to-back pixels need no gap: a d_first arriving in the cycle after idx=7 starts the next pixel while the previous out_valid pulses.
- Output registers:
  - lbp_code, ones and uniform are updated only with out_valid and hold their values between pulses.
  - out_valid and err are single-cycle pulses.
  - uniform = (popcount(code XOR rotate_right(code,1)) <= 2). 0x00 and 0xFF give uniform=1.
- No backpressure: the block always accepts.

Test Plan:
1. Pixel with LATENCY=3, in_first at cycle 0, in_valid cycles 0..7, center=100. I at cycles 3..10 = 120,90,100,50,200,99,101,0 -> out_valid only at cycle 11; lbp_code=0x55, ones=4, uniform=0, err=0.
2. center=10, I all 10 -> lbp_code=0xFF, ones=8, uniform=1. Then center=255, I = 254 x7 then 255 -> lbp_code=0x80, ones=1, uniform=1.
3. Bubbles: same data as scenario 1 with in_valid deasserted for 2 cycles after samples 2 and 5 -> identical outputs; out_valid at cycle 15.
4. Early restart: in_first at cycle 0, then a second in_first at cycle 5 (center=0), 8 samples all 0 -> err pulses once, at cycle 9; out_valid at cycle 16 with lbp_code=0xFF. No out_valid for the aborted pixel.
5. Orphan sample: in_valid=1, in_first=0 while IDLE -> err pulse LATENCY+1 cycles later; no out_valid; the next valid pixel decodes correctly.
6. Reset mid-pixel after 4 samples, then a full pixel with code 0x0F -> all outputs 0 right after reset; no stale partial pixel; single out_valid with lbp_code=0x0F, ones=4, uniform=1.
